// File: rtl/result_topk.sv
// result_topk: classifier output stage. Streams NUM_CLASSES signed scores out
// of pixel memory, tracks the best and second-best class, and reports both
// indices plus the score margin between them before raising STOP.
module result_topk #(
  parameter int SIZE             = 8,
  parameter int SIZE_address_pix = 13,
  parameter int NUM_CLASSES      = 11,
  parameter int IDX_W            = 4,
  parameter int READ_LAT         = 2,
  parameter int TIE_LAST         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic signed [SIZE-1:0]      qp,
  output logic                        re,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic                        STOP,
  output logic [IDX_W-1:0]            RESULT,
  output logic [IDX_W-1:0]            RESULT2,
  output logic [SIZE:0]               MARGIN
);

  // Counters carry one extra bit so they can reach NUM_CLASSES itself.
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] N_C    = CW'(NUM_CLASSES);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_CLASSES - 1);
  localparam logic signed [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic                          re_q, re_d;
  logic                          stop_q, stop_d;
  logic [SIZE_address_pix-1:0]   addr_q, addr_d;
  logic [SIZE_address_pix-1:0]   base_q, base_d;
  logic [CW-1:0]                 iss_q, iss_d;
  logic [CW-1:0]                 cap_q, cap_d;
  logic [READ_LAT-1:0]           vld_q, vld_d;
  logic [IDX_W-1:0]              result_q, result_d;
  logic [IDX_W-1:0]              result2_q, result2_d;
  logic [SIZE:0]                 margin_q, margin_d;
  logic signed [SIZE-1:0]        best_q, best_d;
  logic signed [SIZE-1:0]        second_q, second_d;
  logic [IDX_W-1:0]              bidx_q, bidx_d;
  logic [IDX_W-1:0]              sidx_q, sidx_d;
  logic                          issue;
  logic                          abort;

  // Tie policy: with TIE_LAST a later equal score displaces the held one.
  function automatic logic beats(input logic signed [SIZE-1:0] x,
                                 input logic signed [SIZE-1:0] r);
    if (TIE_LAST != 0) return (x >= r);
    else               return (x > r);
  endfunction

  // Difference at SIZE+1 bits so the full signed span (e.g. 127 - -128) fits.
  function automatic logic [SIZE:0] margin_of(input logic signed [SIZE-1:0] hi,
                                              input logic signed [SIZE-1:0] lo);
    logic signed [SIZE:0] diff;
    diff = (SIZE+1)'(hi) - (SIZE+1)'(lo);
    return $unsigned(diff);
  endfunction

  // Next-state, address issue, capture tracking and completion.
  always_comb begin
    state_d   = state_q;
    re_d      = re_q;
    stop_d    = stop_q;
    addr_d    = addr_q;
    base_d    = base_q;
    iss_d     = iss_q;
    cap_d     = cap_q;
    result_d  = result_q;
    result2_d = result2_q;
    margin_d  = margin_q;
    best_d    = best_q;
    second_d  = second_q;
    bidx_d    = bidx_q;
    sidx_d    = sidx_q;
    issue     = 1'b0;
    abort     = 1'b0;
    vld_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          base_d  = memstartp;
          addr_d  = memstartp;
          re_d    = 1'b1;
          issue   = 1'b1;
          iss_d   = CW'(1);
          cap_d   = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (!enable) begin
          abort   = 1'b1;
          re_d    = 1'b0;
          stop_d  = 1'b0;
          iss_d   = '0;
          cap_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (iss_q < N_C) begin
            addr_d = base_q + SIZE_address_pix'(iss_q);
            iss_d  = iss_q + 1'b1;
            issue  = 1'b1;
          end
          if (vld_q[READ_LAT-1]) begin
            cap_d = cap_q + 1'b1;
            if (cap_q == LAST_C) re_d = 1'b0;
            if (cap_q == '0) begin
              best_d   = qp;
              bidx_d   = '0;
              second_d = MOST_NEG;
              sidx_d   = '0;
            end else if (beats(qp, best_q)) begin
              second_d = best_q;
              sidx_d   = bidx_q;
              best_d   = qp;
              bidx_d   = IDX_W'(cap_q);
            end else if (beats(qp, second_q)) begin
              second_d = qp;
              sidx_d   = IDX_W'(cap_q);
            end
          end
          if (cap_q == N_C) begin
            result_d  = bidx_q;
            result2_d = sidx_q;
            margin_d  = margin_of(best_q, second_q);
            stop_d    = 1'b1;
            re_d      = 1'b0;
            state_d   = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!enable) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        re_d    = 1'b0;
        stop_d  = 1'b0;
      end
    endcase

    // Valid pipe: one tag per issued address, aligned to its capture edge.
    vld_d[0] = issue;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = abort ? 1'b0 : vld_q[i-1];
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      re_q      <= 1'b0;
      stop_q    <= 1'b0;
      addr_q    <= '0;
      iss_q     <= '0;
      cap_q     <= '0;
      vld_q     <= '0;
      result_q  <= '0;
      result2_q <= '0;
      margin_q  <= '0;
    end else begin
      state_q   <= state_d;
      re_q      <= re_d;
      stop_q    <= stop_d;
      addr_q    <= addr_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      vld_q     <= vld_d;
      result_q  <= result_d;
      result2_q <= result2_d;
      margin_q  <= margin_d;
    end
  end

  // Datapath registers; always reloaded by the first capture of a run.
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    best_q   <= best_d;
    second_q <= second_d;
    bidx_q   <= bidx_d;
    sidx_q   <= sidx_d;
  end

  assign re            = re_q;
  assign read_addressp = addr_q;
  assign STOP          = stop_q;
  assign RESULT        = result_q;
  assign RESULT2       = result2_q;
  assign MARGIN        = margin_q;

endmodule

// File: tb/tb_result_topk.sv
// Testbench for result_topk: five instances with different class counts,
// read latencies and tie policies, each fed by its own latency memory model.
module tb_result_topk;

  function automatic int cfg_n(input int g);
    return (g == 2) ? 5 : 11;
  endfunction
  function automatic int cfg_rl(input int g);
    case (g)
      2:       return 1;
      3:       return 3;
      4:       return 4;
      default: return 2;
    endcase
  endfunction
  function automatic int cfg_tie(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  logic              clk;
  logic [4:0]        rst;
  logic [4:0]        en;
  logic [12:0]       base [5];
  logic signed [7:0] qp   [5];
  logic [4:0]        re;
  logic [12:0]       addr [5];
  logic [4:0]        stop;
  logic [3:0]        res  [5];
  logic [3:0]        res2 [5];
  logic [8:0]        mar  [5];
  logic signed [7:0] mem  [5][8192];

  int checks;
  int fails;
  logic [12:0] alog [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int RL = cfg_rl(g);
    logic [12:0] dl [4];
    always @(posedge clk) begin
      dl[0] <= addr[g];
      for (int j = 1; j < 4; j++) dl[j] <= dl[j-1];
    end
    assign qp[g] = (RL == 1) ? mem[g][addr[g]] : mem[g][dl[(RL > 1) ? RL-2 : 0]];

    result_topk #(
      .SIZE(8), .SIZE_address_pix(13), .NUM_CLASSES(cfg_n(g)), .IDX_W(4),
      .READ_LAT(RL), .TIE_LAST(cfg_tie(g))
    ) dut (
      .clk(clk), .rst(rst[g]), .enable(en[g]), .memstartp(base[g]), .qp(qp[g]),
      .re(re[g]), .read_addressp(addr[g]), .STOP(stop[g]),
      .RESULT(res[g]), .RESULT2(res2[g]), .MARGIN(mar[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int b, input logic signed [7:0] v [11], input int n);
    base[i] = 13'(b);
    for (int k = 0; k < n; k++) mem[i][(b + k) % 8192] = v[k];
  endtask

  // Raise enable and count edges until STOP; lat = -1 if it never comes.
  task automatic do_run(input int i, output int lat, output int rc);
    int n;
    lat = -1; rc = 0; n = 0;
    en[i] = 1'b1;
    while (n < 40 && lat < 0) begin
      step();
      if (n < 16) alog[n] = addr[i];
      n++;
      if (re[i]) rc++;
      if (stop[i]) lat = n - 1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks++; if (re[i] !== 1'b0) begin fails++; $display("FAIL reset_re[%0d]: got %0d want 0", i, re[i]); end
      checks++; if (stop[i] !== 1'b0) begin fails++; $display("FAIL reset_stop[%0d]: got %0d want 0", i, stop[i]); end
      checks++; if (addr[i] !== 13'd0) begin fails++; $display("FAIL reset_addr[%0d]: got %0d want 0", i, addr[i]); end
      checks++; if (res[i] !== 4'd0 || res2[i] !== 4'd0) begin fails++; $display("FAIL reset_idx[%0d]: got %0d/%0d want 0/0", i, res[i], res2[i]); end
      checks++; if (mar[i] !== 9'd0) begin fails++; $display("FAIL reset_margin[%0d]: got %0d want 0", i, mar[i]); end
    end
  endtask

  task automatic test_main();
    logic signed [7:0] sc [11];
    int lat, rc;
    sc = '{3, -5, 9, 1, 0, 2, -1, 7, 4, 6, 8};
    load(0, 100, sc, 11);
    do_run(0, lat, rc);
    checks++; if (lat !== 13) begin fails++; $display("FAIL main_latency: got %0d want 13", lat); end
    checks++; if (rc !== 12) begin fails++; $display("FAIL main_re_cycles: got %0d want 12", rc); end
    for (int k = 0; k < 11; k++) begin
      checks++; if (alog[k] !== 13'(100 + k)) begin fails++; $display("FAIL main_addr[%0d]: got %0d want %0d", k, alog[k], 100 + k); end
    end
    checks++; if (res[0] !== 4'd2) begin fails++; $display("FAIL main_result: got %0d want 2", res[0]); end
    checks++; if (res2[0] !== 4'd10) begin fails++; $display("FAIL main_result2: got %0d want 10", res2[0]); end
    checks++; if (mar[0] !== 9'd1) begin fails++; $display("FAIL main_margin: got %0d want 1", mar[0]); end
    step();
    checks++; if (stop[0] !== 1'b1) begin fails++; $display("FAIL main_stop_hold: got %0d want 1", stop[0]); end
    en[0] = 1'b0;
    step();
    checks++; if (stop[0] !== 1'b0) begin fails++; $display("FAIL main_stop_clear: got %0d want 0", stop[0]); end
    checks++; if (res[0] !== 4'd2) begin fails++; $display("FAIL main_result_keep: got %0d want 2", res[0]); end
  endtask

  task automatic test_ties();
    logic signed [7:0] sc [11];
    int lat, rc;
    sc = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    load(0, 300, sc, 11);
    load(1, 300, sc, 11);
    fork
      begin int l0, r0; do_run(0, l0, r0); end
      begin do_run(1, lat, rc); end
    join
    checks++; if (res[0] !== 4'd10 || res2[0] !== 4'd9) begin fails++; $display("FAIL tie_last_idx: got %0d/%0d want 10/9", res[0], res2[0]); end
    checks++; if (mar[0] !== 9'd0) begin fails++; $display("FAIL tie_last_margin: got %0d want 0", mar[0]); end
    checks++; if (res[1] !== 4'd0 || res2[1] !== 4'd1) begin fails++; $display("FAIL tie_first_idx: got %0d/%0d want 0/1", res[1], res2[1]); end
    checks++; if (mar[1] !== 9'd0) begin fails++; $display("FAIL tie_first_margin: got %0d want 0", mar[1]); end
    en[0] = 1'b0; en[1] = 1'b0;
    step();
  endtask

  task automatic test_margin_extreme();
    logic signed [7:0] sc [11];
    int lat, rc;
    sc = '{-128, -128, -128, -128, 127, -128, -128, -128, -128, -128, -128};
    load(0, 500, sc, 11);
    do_run(0, lat, rc);
    checks++; if (res[0] !== 4'd4) begin fails++; $display("FAIL extreme_result: got %0d want 4", res[0]); end
    checks++; if (res2[0] !== 4'd10) begin fails++; $display("FAIL extreme_result2: got %0d want 10", res2[0]); end
    checks++; if (mar[0] !== 9'd255) begin fails++; $display("FAIL extreme_margin: got %0d want 255", mar[0]); end
    en[0] = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    logic signed [7:0] sc [11];
    logic [12:0] exp_a [5];
    int lat, rc;
    sc = '{-3, 20, 7, 20, -100, 0, 0, 0, 0, 0, 0};
    exp_a = '{13'd8189, 13'd8190, 13'd8191, 13'd0, 13'd1};
    load(2, 8189, sc, 5);
    do_run(2, lat, rc);
    checks++; if (lat !== 6) begin fails++; $display("FAIL wrap_latency_rl1: got %0d want 6", lat); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (alog[k] !== exp_a[k]) begin fails++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, alog[k], exp_a[k]); end
    end
    checks++; if (res[2] !== 4'd3 || res2[2] !== 4'd1) begin fails++; $display("FAIL wrap_idx: got %0d/%0d want 3/1", res[2], res2[2]); end
    checks++; if (mar[2] !== 9'd0) begin fails++; $display("FAIL wrap_margin: got %0d want 0", mar[2]); end
    en[2] = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic signed [7:0] sc [11];
    int lat, rc;
    logic seen;
    sc = '{3, -5, 9, 1, 0, 2, -1, 7, 4, 6, 8};
    load(0, 700, sc, 11);
    en[0] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    en[0] = 1'b0;
    step();
    checks++; if (re[0] !== 1'b0) begin fails++; $display("FAIL abort_re: got %0d want 0", re[0]); end
    checks++; if (res[0] !== 4'd4 || res2[0] !== 4'd10) begin fails++; $display("FAIL abort_keep_idx: got %0d/%0d want 4/10", res[0], res2[0]); end
    checks++; if (mar[0] !== 9'd255) begin fails++; $display("FAIL abort_keep_margin: got %0d want 255", mar[0]); end
    seen = stop[0];
    for (int k = 0; k < 20; k++) begin step(); seen = seen | stop[0]; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_stop_seen: got %0d want 0", seen); end
    sc = '{10, -20, 30, -40, 50, -60, 70, -80, 90, -100, 100};
    load(0, 900, sc, 11);
    do_run(0, lat, rc);
    checks++; if (lat !== 13) begin fails++; $display("FAIL rerun_latency: got %0d want 13", lat); end
    checks++; if (res[0] !== 4'd10 || res2[0] !== 4'd8) begin fails++; $display("FAIL rerun_idx: got %0d/%0d want 10/8", res[0], res2[0]); end
    checks++; if (mar[0] !== 9'd10) begin fails++; $display("FAIL rerun_margin: got %0d want 10", mar[0]); end
    en[0] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_read();
    en[0] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst[0] = 1'b1;
    step();
    checks++; if (re[0] !== 1'b0 || stop[0] !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: got re=%0d stop=%0d want 0/0", re[0], stop[0]); end
    checks++; if (addr[0] !== 13'd0) begin fails++; $display("FAIL midrst_addr: got %0d want 0", addr[0]); end
    checks++; if (res[0] !== 4'd0 || res2[0] !== 4'd0 || mar[0] !== 9'd0) begin fails++; $display("FAIL midrst_outs: got %0d/%0d/%0d want 0/0/0", res[0], res2[0], mar[0]); end
    en[0] = 1'b0;
    rst[0] = 1'b0;
    step();
  endtask

  task automatic test_latency_sweep();
    logic signed [7:0] sc [11];
    int lat3, rc3, lat4, rc4;
    sc = '{3, -5, 9, 1, 0, 2, -1, 7, 4, 6, 8};
    load(3, 40, sc, 11);
    load(4, 8185, sc, 11);
    fork
      do_run(3, lat3, rc3);
      do_run(4, lat4, rc4);
    join
    checks++; if (lat3 !== 14) begin fails++; $display("FAIL rl3_latency: got %0d want 14", lat3); end
    checks++; if (lat4 !== 15) begin fails++; $display("FAIL rl4_latency: got %0d want 15", lat4); end
    checks++; if (res[3] !== 4'd2 || res2[3] !== 4'd10 || mar[3] !== 9'd1) begin fails++; $display("FAIL rl3_outs: got %0d/%0d/%0d want 2/10/1", res[3], res2[3], mar[3]); end
    checks++; if (res[4] !== 4'd2 || res2[4] !== 4'd10 || mar[4] !== 9'd1) begin fails++; $display("FAIL rl4_outs: got %0d/%0d/%0d want 2/10/1", res[4], res2[4], mar[4]); end
    // Instance 3 sits in DONE with enable high; reset it there.
    rst[3] = 1'b1;
    step();
    checks++; if (stop[3] !== 1'b0 || re[3] !== 1'b0) begin fails++; $display("FAIL donerst_ctrl: got stop=%0d re=%0d want 0/0", stop[3], re[3]); end
    checks++; if (res[3] !== 4'd0 || res2[3] !== 4'd0 || mar[3] !== 9'd0) begin fails++; $display("FAIL donerst_outs: got %0d/%0d/%0d want 0/0/0", res[3], res2[3], mar[3]); end
    checks++; if (addr[3] !== 13'd0) begin fails++; $display("FAIL donerst_addr: got %0d want 0", addr[3]); end
    en[3] = 1'b0; en[4] = 1'b0;
    rst[3] = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst = '1;
    en  = '0;
    for (int i = 0; i < 5; i++) base[i] = '0;
    step();
    step();
    test_reset();
    rst = '0;
    step();
    test_main();
    test_ties();
    test_margin_extreme();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/result_topk.md
Name: result_topk

Overview:
- Parametrised classifier output stage. Runs after the last dense layer has written NUM_CLASSES signed scores to pixel memory.
- Streams the scores out by address and tracks the best and second-best class.
- Reports both indices and the score margin between them, and asserts STOP when done.
- Successor to the fixed 11-class argmax stage. Adds configurable class count, memory read latency and tie policy, a runner-up class, a confidence margin, and a synchronous reset.

Parameters:
- SIZE, 8, score width in bits (two's complement).
- SIZE_address_pix, 13, pixel memory address width.
- NUM_CLASSES, 11, number of scores to scan; legal range 2..2^IDX_W.
- IDX_W, 4, width of the class-index outputs; must satisfy 2^IDX_W >= NUM_CLASSES.
- READ_LAT, 2, cycles from a registered read_addressp to the matching qp being sampled; legal range 1..4.
- TIE_LAST, 1, tie policy: 1 = a later equal score wins (>=); 0 = an earlier equal score wins (>).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level request; high = run/hold, low = abort/idle.
- memstartp  in  SIZE_address_pix  base address of score 0; sampled at start.
- qp  in  SIZE  memory read data.
- re  out  1  memory read enable.
- read_addressp  out  SIZE_address_pix  memory read address.
- STOP  out  1  done flag.
- RESULT  out  IDX_W  index of the best class.
- RESULT2  out  IDX_W  index of the second-best class.
- MARGIN  out  SIZE+1  unsigned value of best score minus second score.

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything): state IDLE; re=0, STOP=0, read_addressp=0, RESULT=0, RESULT2=0, MARGIN=0; issue counter, capture counter and valid pipe cleared.
- State IDLE:
  - At an edge with enable=1: latch base=memstartp; read_addressp=memstartp; re=1; go to READ. Call this edge t0.
  - enable=0: remain in IDLE.
- State READ:
  - At edges t0+1 .. t0+NUM_CLASSES-1, read_addressp = base+k for k=1..NUM_CLASSES-1, one address per cycle.
  - After the last address, re holds 1 until the last capture. read_addressp holds its last value.
- Address arithmetic: base+k is modulo 2^SIZE_address_pix; wrap is allowed and not flagged.
- Capture timing:
  - The qp for address base+k is sampled at edge t0+k+READ_LAT.
  - A READ_LAT-deep valid shift register tags each capture with its index k.
- Update rule for capture k with value x (signed compare):
  - k=0: best=x, bidx=0, second=most-negative SIZE value, sidx=0.
  - else if x>best (or x>=best when TIE_LAST=1): second=best, sidx=bidx, best=x, bidx=k.
  - else if x>second (or x>=second when TIE_LAST=1): second=x, sidx=k.
  - else: no change.
- Completion:
  - At the edge after the final capture (t0+NUM_CLASSES+READ_LAT): RESULT=bidx, RESULT2=sidx, MARGIN=best-second computed at SIZE+1 bits (never negative); STOP=1; re=0; go to DONE.
  - Total latency from t0 to STOP=1: NUM_CLASSES+READ_LAT edges.
- State DONE:
  - Outputs and STOP hold while enable=1.
  - At an edge with enable=0: STOP=0, go to IDLE. RESULT, RESULT2 and MARGIN keep their values until the next completion or reset.
  - A new run needs enable to return low for at least one cycle.
- Abort: enable=0 at any edge in READ goes to IDLE with re=0 and STOP=0. Partial results are discarded and RESULT, RESULT2 and MARGIN are not updated.
- Internal best and second registers are SIZE wide; tracking involves no overflow.
- enable is not sampled as an edge, only as a level.

Test Plan:
- Scores [3,-5,9,1,0,2,-1,7,4,6,8], READ_LAT=2 -> STOP rises 13 edges after t0. RESULT=2, RESULT2=10, MARGIN=1. re high for exactly 12 cycles.
- Ties [5,5,5,...] with TIE_LAST=1 -> RESULT=10, RESULT2=9, MARGIN=0. Same scores with TIE_LAST=0 -> RESULT=0, RESULT2=1, MARGIN=0.
- SIZE=8, scores with -128 at index 0 and 127 at index 4, all others -128 -> RESULT=4, MARGIN=255 (checks the 9-bit margin).
- memstartp=2^13-3, NUM_CLASSES=5 -> addresses 8189, 8190, 8191, 0, 1 in that order. Check result correctness.
- Drop enable at t0+4 -> IDLE next edge, re=0, STOP never asserts, previous RESULT unchanged. Then run again -> correct result.
- Assert rst mid-READ, and separately in DONE -> all outputs zero on the next edge. Also sweep READ_LAT=1, 3 and 4 -> STOP latency equals NUM_CLASSES+READ_LAT.
